// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate access controller and its password checker.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_FAIL    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GRANT   = 3'd4,
    ST_LOCK    = 3'd5
  } state_t;

  localparam int MAX_TRIES_DEF = 3;

  // Button codes as emitted by the password checker keypad.
  typedef enum logic [2:0] {
    BTN_NONE   = 3'd0,
    BTN_LEFT   = 3'd1,
    BTN_RIGHT  = 3'd2,
    BTN_UP     = 3'd3,
    BTN_DOWN   = 3'd4,
    BTN_CENTER = 3'd5
  } button_t;

  // Remaining-tries decrement that holds at zero.
  function automatic logic [1:0] tries_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/parking_access_ctrl_if.sv
// Signal bundle between the gate controller and the car sensor, password checker and gate/LED drivers.
interface parking_access_ctrl_if;
  logic       car_arrive;
  logic       car_passed;
  logic       pwdone;
  logic       pw_correct;
  logic       pwstart;
  logic       gate_open;
  logic       alarm;
  logic [1:0] attempts_left;
  logic       busy;

  modport master (
    output car_arrive, car_passed, pwdone, pw_correct,
    input  pwstart, gate_open, alarm, attempts_left, busy
  );

  modport slave (
    input  car_arrive, car_passed, pwdone, pw_correct,
    output pwstart, gate_open, alarm, attempts_left, busy
  );
endinterface

// File: rtl/park_timer.sv
// Loadable down-counter that stops at zero; zero flags an expired interval.
module park_timer #(
  parameter int CNT_W = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/parking_access_ctrl.sv
// Parking gate sequencer: arms the password checker, counts wrong attempts,
// opens the gate on success and locks out with an alarm after too many failures.
module parking_access_ctrl
  import parking_pkg::*;
#(
  parameter int MAX_TRIES      = MAX_TRIES_DEF,
  parameter int GATE_CYCLES    = 500000000,
  parameter int LOCK_CYCLES    = 1000000000,
  parameter int TIMEOUT_CYCLES = 1000000000,
  parameter int CNT_W          = 30
) (
  input logic                  clk,
  input logic                  rst,
  parking_access_ctrl_if.slave bus
);

  localparam logic [1:0]       TRIES_INIT = 2'(MAX_TRIES);
  localparam logic [CNT_W-1:0] TMO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LOAD  = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [1:0]       attempts_reg, attempts_next;
  logic             pwdone_q_reg;
  logic             pwstart_reg, gate_open_reg, alarm_reg, busy_reg;
  logic             done_rise;
  logic             timer_load, timer_en, timer_zero;
  logic [CNT_W-1:0] timer_val;

  // A held button must register as one verdict only.
  assign done_rise = bus.pwdone & ~pwdone_q_reg;
  assign timer_en  = (state_reg == ST_ARM) || (state_reg == ST_GRANT) || (state_reg == ST_LOCK);

  park_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .zero     (timer_zero)
  );

  always_comb begin
    state_next    = state_reg;
    attempts_next = attempts_reg;
    timer_load    = 1'b0;
    timer_val     = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.car_arrive) begin
          state_next = ST_ARM;
          timer_load = 1'b1;
          timer_val  = TMO_LOAD;
        end
      end
      ST_ARM: begin
        // A verdict beats an expiring attempt, which beats the car leaving.
        if (done_rise) begin
          if (bus.pw_correct) begin
            state_next    = ST_GRANT;
            timer_load    = 1'b1;
            timer_val     = GATE_LOAD;
            attempts_next = TRIES_INIT;
          end else begin
            state_next = ST_FAIL;
          end
        end else if (timer_zero) begin
          state_next = ST_FAIL;
        end else if (!bus.car_arrive) begin
          state_next = ST_IDLE;
        end
      end
      ST_FAIL: begin
        attempts_next = tries_dec(attempts_reg);
        if (attempts_next == 2'd0) begin
          state_next = ST_LOCK;
          timer_load = 1'b1;
          timer_val  = LOCK_LOAD;
        end else begin
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!bus.car_arrive) begin
          state_next = ST_IDLE;
        end else if (!bus.pwdone) begin
          state_next = ST_ARM;
          timer_load = 1'b1;
          timer_val  = TMO_LOAD;
        end
      end
      ST_GRANT: begin
        if (bus.car_passed || timer_zero) begin
          state_next = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (timer_zero) begin
          state_next    = ST_IDLE;
          attempts_next = TRIES_INIT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      attempts_reg  <= TRIES_INIT;
      pwdone_q_reg  <= 1'b0;
      pwstart_reg   <= 1'b0;
      gate_open_reg <= 1'b0;
      alarm_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      attempts_reg  <= attempts_next;
      pwdone_q_reg  <= bus.pwdone;
      pwstart_reg   <= (state_next == ST_ARM);
      gate_open_reg <= (state_next == ST_GRANT);
      alarm_reg     <= (state_next == ST_LOCK);
      busy_reg      <= (state_next != ST_IDLE);
    end
  end

  assign bus.pwstart       = pwstart_reg;
  assign bus.gate_open     = gate_open_reg;
  assign bus.alarm         = alarm_reg;
  assign bus.attempts_left = attempts_reg;
  assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_parking_access_ctrl.sv
// Bench for parking_access_ctrl: vector table, directed corner sequences and a randomized run
// checked against a cycle-budget model of the access rules.
module tb_parking_access_ctrl;

  localparam int GATE_C = 8;
  localparam int LOCK_C = 16;
  localparam int TMO_C  = 20;
  localparam int MAX_T  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  parking_access_ctrl_if bus();

  parking_access_ctrl #(
    .MAX_TRIES      (MAX_T),
    .GATE_CYCLES    (GATE_C),
    .LOCK_CYCLES    (LOCK_C),
    .TIMEOUT_CYCLES (TMO_C),
    .CNT_W          (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, car, passed, done, corr;
    int ps, go, al, att, bz;
  } vec_t;

  vec_t vecs[18];

  // Reference model: what the gate is doing plus the cycles it has left in that activity.
  typedef enum int {M_WAIT, M_TRY, M_MISS, M_HOLD, M_OPEN, M_ALARM} mphase_t;
  mphase_t m_phase;
  int      m_left;
  int      m_tries;
  bit      m_done_q;

  function automatic void model_step(bit r, bit car, bit passed, bit done, bit corr);
    bit rise;
    rise = done && !m_done_q;
    if (r) begin
      m_phase  = M_WAIT;
      m_left   = 0;
      m_tries  = MAX_T;
      m_done_q = 1'b0;
      return;
    end
    m_done_q = done;
    case (m_phase)
      M_WAIT:  if (car) begin m_phase = M_TRY; m_left = TMO_C; end
      M_TRY: begin
        if (rise && corr) begin
          m_phase = M_OPEN; m_left = GATE_C; m_tries = MAX_T;
        end else if (rise || m_left <= 1) begin
          m_phase = M_MISS;
        end else if (!car) begin
          m_phase = M_WAIT;
        end else begin
          m_left--;
        end
      end
      M_MISS: begin
        m_tries = (m_tries > 0) ? m_tries - 1 : 0;
        if (m_tries == 0) begin m_phase = M_ALARM; m_left = LOCK_C; end
        else m_phase = M_HOLD;
      end
      M_HOLD: begin
        if (!car) m_phase = M_WAIT;
        else if (!done) begin m_phase = M_TRY; m_left = TMO_C; end
      end
      M_OPEN:  if (passed || m_left <= 1) m_phase = M_WAIT; else m_left--;
      M_ALARM: if (m_left <= 1) begin m_phase = M_WAIT; m_tries = MAX_T; end else m_left--;
      default: m_phase = M_WAIT;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit car, input bit passed, input bit done, input bit corr);
    rst            = r;
    bus.car_arrive = car;
    bus.car_passed = passed;
    bus.pwdone     = done;
    bus.pw_correct = corr;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pwstart"}, int'(bus.pwstart), 0);
    chk({tag, "_gate"}, int'(bus.gate_open), 0);
    chk({tag, "_alarm"}, int'(bus.alarm), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_attempts"}, int'(bus.attempts_left), MAX_T);
  endtask

  // One wrong entry with the button held for three cycles.
  task automatic wrong_entry();
    bus.pwdone = 1'b1; bus.pw_correct = 1'b0;
    tick(); tick(); tick();
    bus.pwdone = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    drive(1, 0, 0, 0, 0);

    // rst car passed done corr | pwstart gate alarm attempts busy
    vecs = '{
      '{1,0,0,0,0, 0,0,0,3,0}, '{0,1,0,0,0, 1,0,0,3,1}, '{0,1,0,0,0, 1,0,0,3,1},
      '{0,1,0,1,1, 0,1,0,3,1}, '{0,1,0,1,1, 0,1,0,3,1}, '{0,0,0,0,0, 0,1,0,3,1},
      '{0,0,1,0,0, 0,0,0,3,0}, '{0,0,0,0,0, 0,0,0,3,0}, '{0,1,0,0,0, 1,0,0,3,1},
      '{0,1,0,1,0, 0,0,0,3,1}, '{0,1,0,1,0, 0,0,0,2,1}, '{0,1,0,1,0, 0,0,0,2,1},
      '{0,1,0,0,0, 1,0,0,2,1}, '{0,0,0,0,0, 0,0,0,2,0}, '{0,1,1,0,0, 1,0,0,2,1},
      '{0,1,0,1,1, 0,1,0,3,1}, '{0,0,0,1,1, 0,1,0,3,1}, '{1,0,0,0,0, 0,0,0,3,0}
    };

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].r != 0, vecs[i].car != 0, vecs[i].passed != 0, vecs[i].done != 0, vecs[i].corr != 0);
      tick();
      $display("vec %0d: rst=%0d car=%0d passed=%0d done=%0d corr=%0d -> pwstart=%0d gate=%0d alarm=%0d att=%0d busy=%0d",
               i, vecs[i].r, vecs[i].car, vecs[i].passed, vecs[i].done, vecs[i].corr,
               bus.pwstart, bus.gate_open, bus.alarm, bus.attempts_left, bus.busy);
      chk($sformatf("vec%0d_pwstart", i), int'(bus.pwstart), vecs[i].ps);
      chk($sformatf("vec%0d_gate", i), int'(bus.gate_open), vecs[i].go);
      chk($sformatf("vec%0d_alarm", i), int'(bus.alarm), vecs[i].al);
      chk($sformatf("vec%0d_attempts", i), int'(bus.attempts_left), vecs[i].att);
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), vecs[i].bz);
    end

    // Three wrong entries lead to a lockout of LOCK_C cycles.
    drive(0, 1, 0, 0, 0);
    tick();
    chk("lock_armed", int'(bus.pwstart), 1);
    for (int k = 0; k < 2; k++) begin
      wrong_entry();
      chk($sformatf("lock_att_after_%0d", k + 1), int'(bus.attempts_left), MAX_T - 1 - k);
      chk($sformatf("lock_rearmed_%0d", k + 1), int'(bus.pwstart), 1);
    end
    bus.pwdone = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) bus.pwdone = 1'b0;
      tick();
      if (i == 0) chk("lock_att_zero", int'(bus.attempts_left), 0);
      if (bus.alarm) n++;
      else if (n > 0) break;
    end
    $display("lockout: alarm high %0d cycles", n);
    chk("lock_alarm_len", n, LOCK_C);
    chk("lock_att_restored", int'(bus.attempts_left), MAX_T);
    chk("lock_idle", int'(bus.busy), 0);

    // Timeout with a button held since before arming: one lost try only.
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    bus.car_arrive = 1'b1; tick();
    n = 0;
    for (int i = 0; i < 60 && bus.pwstart; i++) begin
      n++;
      tick();
    end
    $display("timeout: pwstart high %0d cycles", n);
    chk("tmo_arm_len", n, TMO_C);
    tick();
    chk("tmo_att", int'(bus.attempts_left), MAX_T - 1);
    chk("tmo_pwstart_low", int'(bus.pwstart), 0);
    tick(); tick(); tick();
    chk("tmo_held_no_double", int'(bus.attempts_left), MAX_T - 1);
    bus.pwdone = 1'b0; tick();
    chk("tmo_rearm", int'(bus.pwstart), 1);

    // Grant with no car_passed closes after GATE_C cycles.
    bus.pwdone = 1'b1; bus.pw_correct = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 60 && bus.gate_open; i++) begin
      n++;
      tick();
    end
    $display("auto-close: gate open %0d cycles", n);
    chk("auto_gate_len", n, GATE_C);
    chk("auto_att", int'(bus.attempts_left), MAX_T);
    chk("auto_idle", int'(bus.busy), 0);

    // Correct entry on the timer==0 cycle still grants.
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0); tick();
    for (int i = 0; i < TMO_C - 1; i++) tick();
    chk("coin_still_armed", int'(bus.pwstart), 1);
    bus.pwdone = 1'b1; bus.pw_correct = 1'b1;
    tick();
    $display("coincidence: gate=%0d", bus.gate_open);
    chk("coin_grant", int'(bus.gate_open), 1);

    // Car leaves mid-attempt: tries kept; a verdict beats the car leaving.
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0); tick();
    bus.pwdone = 1'b1; tick();
    bus.pwdone = 1'b0; tick(); tick(); tick();
    bus.car_arrive = 1'b0; tick();
    $display("car drop: busy=%0d att=%0d", bus.busy, bus.attempts_left);
    chk("drop_idle", int'(bus.busy), 0);
    chk("drop_att_kept", int'(bus.attempts_left), MAX_T - 1);
    bus.car_arrive = 1'b1; tick();
    bus.car_arrive = 1'b0; bus.pwdone = 1'b1; bus.pw_correct = 1'b1; tick();
    chk("drop_rise_wins", int'(bus.gate_open), 1);

    // Reset while the gate is open, then while locked out.
    drive(1, 0, 0, 0, 0); tick();
    $display("rst in grant: gate=%0d busy=%0d", bus.gate_open, bus.busy);
    chk_reset_vals("rst_grant");
    drive(0, 1, 0, 0, 0); tick();
    wrong_entry(); wrong_entry(); wrong_entry();
    chk("rst_lock_reached", int'(bus.alarm), 1);
    rst = 1'b1; tick();
    $display("rst in lock: alarm=%0d att=%0d", bus.alarm, bus.attempts_left);
    chk_reset_vals("rst_lock");

    // Randomized run against the model.
    drive(1, 0, 0, 0, 0);
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) bus.car_arrive = ~bus.car_arrive;
      if ($urandom_range(0, 5) == 0) bus.pwdone = ~bus.pwdone;
      bus.pw_correct = ($urandom_range(0, 2) == 0);
      bus.car_passed = ($urandom_range(0, 9) == 0);
      if (bus.pwdone && !m_done_q)
        $display("rand %0d: button edge correct=%0d car=%0d", i, bus.pw_correct, bus.car_arrive);
      model_step(rst, bus.car_arrive, bus.car_passed, bus.pwdone, bus.pw_correct);
      tick();
      chk($sformatf("rand%0d_pwstart", i), int'(bus.pwstart), int'(m_phase == M_TRY));
      chk($sformatf("rand%0d_gate", i), int'(bus.gate_open), int'(m_phase == M_OPEN));
      chk($sformatf("rand%0d_alarm", i), int'(bus.alarm), int'(m_phase == M_ALARM));
      chk($sformatf("rand%0d_attempts", i), int'(bus.attempts_left), m_tries);
      chk($sformatf("rand%0d_busy", i), int'(bus.busy), int'(m_phase != M_WAIT));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
